bot_rod_controller: RTL and testbench
=====================================

BOT_ROD_CONTROLLER -- requirements
Module: bot_rod_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 3: number of players on the rod, 1..4.
REQ-002 Parameter PLAYER_SPACING, default 128: vertical pixel distance between adjacent players' top-left Y.
REQ-003 Parameter INITIAL_X, default 120; INITIAL_Y, default 0: rod top-left position after reset, in pixels.
REQ-004 Parameter TRACK_SPEED, default 50: rod step per frame, in 1/64 pixel.
REQ-005 Parameter DEADBAND, default 4: pixel error at or below which the rod holds position.
REQ-006 Parameter Y_MIN, default 0; Y_MAX, default 192: clamp limits for rod top-left Y, in pixels.
REQ-007 Parameter KICK_FRAMES, default 15; COOLDOWN_FRAMES, default 30: kick and cooldown durations, in frames.
REQ-008 clk  in  1  system clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 startOfFrame  in  1  one-cycle pulse at each frame start.
REQ-011 collision  in  1  rod touches a frame border.
REQ-012 collision1  in  1  rod player touches the ball.
REQ-013 HitEdgeCode  in  4  one bit per edge: [0] bottom, [2] top, [3] side.
REQ-014 ballTLY  in  11  ball top-left Y, in pixels.
REQ-015 kick  out  1  high while the kick is active.
REQ-016 topLeftX  out  11 signed  rod top-left X; constant INITIAL_X.
REQ-017 topLeftY  out  11 signed  rod top-left Y = fixed-point position / 64.

Function
REQ-018 The rod position SHALL be held as a signed fixed-point value scaled by 64.
REQ-019 Position SHALL update only in the cycle where startOfFrame=1; topLeftY SHALL reflect the update on the next cycle.
REQ-020 Lane select: i = clamp((ballTLY - rodY + PLAYER_SPACING/2) / PLAYER_SPACING, 0, NUM_PLAYERS-1), where rodY is topLeftY, evaluated in signed arithmetic.
REQ-021 The error SHALL be e = ballTLY - (rodY + i*PLAYER_SPACING).
REQ-022 Step: if |e| <= DEADBAND, the step is 0; otherwise the step is +TRACK_SPEED when e > 0 and -TRACK_SPEED when e < 0.
REQ-023 Wall block: collision with HitEdgeCode[2] SHALL suppress a negative step, and collision with HitEdgeCode[0] SHALL suppress a positive step.
REQ-024 Each wall-block flag SHALL be sticky from its assertion until the next startOfFrame consumes it, and SHALL clear on that same cycle.
REQ-025 The new position SHALL saturate to [Y_MIN*64, Y_MAX*64], with no wrap-around.
REQ-026 Kick FSM states: IDLE, KICK, COOLDOWN.
REQ-027 IDLE→KICK SHALL occur on collision1 && (HitEdgeCode[0] | HitEdgeCode[2] | HitEdgeCode[3]), any cycle.
REQ-028 KICK→COOLDOWN SHALL occur after KICK_FRAMES startOfFrame pulses; COOLDOWN→IDLE SHALL occur after COOLDOWN_FRAMES startOfFrame pulses.
REQ-029 kick SHALL be 1 only in the KICK state.
REQ-030 Hits arriving in KICK or COOLDOWN SHALL be ignored, with no retrigger.
REQ-031 A hit coincident with startOfFrame in IDLE SHALL enter KICK, and that pulse SHALL NOT count toward KICK_FRAMES.

Reset
REQ-032 When reset=1 at a clk edge: position = INITIAL_Y*64, FSM = IDLE, frame counter = 0, wall flags = 0, kick = 0, topLeftX = INITIAL_X.
REQ-033 Reset SHALL override every simultaneous input, including mid-kick and mid-frame.

Configuration
REQ-034 Macro BOT_PREDICT_EN.
REQ-035 With BOT_PREDICT_EN defined: the target SHALL be ballTLY + 2*(ballTLY - prevBallTLY), saturated to 0..479; prevBallTLY SHALL be latched each startOfFrame and reset to 0.
REQ-036 Without BOT_PREDICT_EN: the target SHALL be ballTLY, and no previous-ball register SHALL exist.

Structure
REQ-037 Package bot_pkg SHALL hold FIXED_POINT_MULTIPLIER (64), FRAME_H (480), and the kick_state_t enum {IDLE, KICK, COOLDOWN}.
REQ-038 Sub-module bot_lane_select SHALL compute, combinationally, lane i and error e from target Y, rodY, NUM_PLAYERS and PLAYER_SPACING.

Verification
REQ-039 Tracking: defaults, ballTLY=300 held → topLeftY rises by 50/64 px per frame and settles at 40 after 52 frames, then holds.
REQ-040 Clamp: ballTLY=479 held → topLeftY saturates at 192 and never exceeds it; ballTLY=0 with rod at 0 → topLeftY stays 0.
REQ-041 Kick: collision1=1 with HitEdgeCode=4'b0001 → kick=1 next cycle for 15 frames, then 0; a second hit during the 30-frame cooldown → kick stays 0.
REQ-042 Wall block: rod moving up, collision with HitEdgeCode[2] pulsed mid-frame → no position change at the next startOfFrame, and movement resumes the frame after.
REQ-043 Reset mid-kick: reset=1 at frame 5 of KICK → kick=0 and topLeftY=0 next cycle; a subsequent hit kicks immediately.
REQ-044 BOT_PREDICT_EN: ballTLY 100 then 110 → target 130, and the lane/error check uses 130.

Source files
------------

// File: rtl/bot_pkg.sv
// bot_pkg: shared constants and kick state encoding for the bot rod controller
package bot_pkg;
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FRAME_H = 480;
  typedef enum logic [1:0] {IDLE, KICK, COOLDOWN} kick_state_t;
endpackage

// File: rtl/bot_lane_select.sv
// bot_lane_select: picks the player lane nearest the target and its Y error
module bot_lane_select #(
  parameter int NUM_PLAYERS = 3,
  parameter int PLAYER_SPACING = 128
) (
  input  logic signed [13:0] target_y,
  input  logic signed [10:0] rod_y,
  output logic        [1:0]  lane,
  output logic signed [13:0] err
);
  logic signed [13:0] rod_ext, d, q;
  // round to the nearest player by biasing with half a spacing, then clamp
  always_comb begin
    rod_ext = 14'(rod_y);
    d = target_y - rod_ext + 14'(PLAYER_SPACING / 2);
    q = d / 14'(PLAYER_SPACING);
    lane = q < 14'sd0 ? 2'd0 : q > 14'(NUM_PLAYERS - 1) ? 2'(NUM_PLAYERS - 1) : q[1:0];
    err = target_y - rod_ext - $signed(14'(lane)) * 14'(PLAYER_SPACING);
  end
endmodule

// File: rtl/bot_rod_controller.sv
// bot_rod_controller: frame-stepped rod tracking with wall blocking and kick FSM (optional BOT_PREDICT_EN)
module bot_rod_controller import bot_pkg::*; #(
  parameter int NUM_PLAYERS = 3,
  parameter int PLAYER_SPACING = 128,
  parameter int INITIAL_X = 120,
  parameter int INITIAL_Y = 0,
  parameter int TRACK_SPEED = 50,
  parameter int DEADBAND = 4,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 192,
  parameter int KICK_FRAMES = 15,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic               collision1,
  input  logic        [3:0]  HitEdgeCode,
  input  logic        [10:0] ballTLY,
  output logic               kick,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY
);
  logic signed [17:0] pos, raw_step, step, sum, nxt;
  logic signed [13:0] target_y, err, e_abs;
  logic        [1:0]  lane;
  logic               top_flag, bot_flag, blk_up, blk_dn, hit;
  kick_state_t        state;
  logic        [15:0] cnt;
  assign topLeftX = 11'(INITIAL_X);
  assign topLeftY = 11'(pos / 18'(FIXED_POINT_MULTIPLIER));
`ifdef BOT_PREDICT_EN
  logic        [10:0] prev_ball;
  logic signed [13:0] ball_s, pred;
  // extrapolate two frames ahead of the observed ball velocity, kept on screen
  always_comb begin
    ball_s = $signed({3'b0, ballTLY});
    pred = ball_s + 14'sd2 * (ball_s - $signed({3'b0, prev_ball}));
    target_y = pred < 14'sd0 ? 14'sd0 : pred > 14'(FRAME_H - 1) ? 14'(FRAME_H - 1) : pred;
  end
  // remember the ball position seen at the last frame start
  always_ff @(posedge clk)
    if (reset) prev_ball <= '0;
    else if (startOfFrame) prev_ball <= ballTLY;
`else
  assign target_y = $signed({3'b0, ballTLY});
`endif
  bot_lane_select #(.NUM_PLAYERS(NUM_PLAYERS), .PLAYER_SPACING(PLAYER_SPACING)) u_lane (
    .target_y(target_y),
    .rod_y(topLeftY),
    .lane(lane),
    .err(err)
  );
  // choose the step, drop it if a wall blocks that direction, then saturate
  always_comb begin
    e_abs = err < 14'sd0 ? -err : err;
    raw_step = e_abs <= 14'(DEADBAND) ? 18'sd0 : err > 14'sd0 ? 18'(TRACK_SPEED) : -18'(TRACK_SPEED);
    blk_up = top_flag | (collision & HitEdgeCode[2]);
    blk_dn = bot_flag | (collision & HitEdgeCode[0]);
    step = (raw_step < 18'sd0 && blk_up) || (raw_step > 18'sd0 && blk_dn) ? 18'sd0 : raw_step;
    sum = pos + step;
    nxt = sum < 18'(Y_MIN * FIXED_POINT_MULTIPLIER) ? 18'(Y_MIN * FIXED_POINT_MULTIPLIER) :
          sum > 18'(Y_MAX * FIXED_POINT_MULTIPLIER) ? 18'(Y_MAX * FIXED_POINT_MULTIPLIER) : sum;
    hit = collision1 & (|(HitEdgeCode & 4'b1101));
  end
  // position advances once per frame; wall flags stick until a frame start consumes them
  always_ff @(posedge clk)
    if (reset) begin
      pos <= 18'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
      top_flag <= 1'b0;
      bot_flag <= 1'b0;
    end else begin
      if (startOfFrame) pos <= nxt;
      top_flag <= startOfFrame ? 1'b0 : top_flag | (collision & HitEdgeCode[2]);
      bot_flag <= startOfFrame ? 1'b0 : bot_flag | (collision & HitEdgeCode[0]);
    end
  // kick FSM: a hit in IDLE kicks; frame starts time out KICK then COOLDOWN
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      kick <= 1'b0;
    end else
      case (state)
        IDLE:
          if (hit) begin
            state <= KICK;
            cnt <= '0;
            kick <= 1'b1;
          end
        KICK:
          if (startOfFrame) begin
            if (cnt == 16'(KICK_FRAMES - 1)) begin
              state <= COOLDOWN;
              cnt <= '0;
              kick <= 1'b0;
            end else cnt <= cnt + 16'd1;
          end
        COOLDOWN:
          if (startOfFrame) begin
            if (cnt == 16'(COOLDOWN_FRAMES - 1)) begin
              state <= IDLE;
              cnt <= '0;
            end else cnt <= cnt + 16'd1;
          end
        default: begin
          state <= IDLE;
          cnt <= '0;
          kick <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_bot_rod_controller.sv
// tb_bot_rod_controller: directed vector table plus kick/clamp/reset sequences
module tb_bot_rod_controller;
  logic clk = 1'b0;
  logic reset, sof, collision, collision1;
  logic [3:0] hec;
  logic [10:0] ball;
  logic kick;
  logic signed [10:0] tlx, tly;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int ball; logic [3:0] hec; int exp_y;} vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  bot_rod_controller dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .collision(collision),
    .collision1(collision1), .HitEdgeCode(hec), .ballTLY(ball),
    .kick(kick), .topLeftX(tlx), .topLeftY(tly)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic hit(input logic [3:0] code);
    collision1 = 1'b1;
    hec = code;
    tick();
    collision1 = 1'b0;
    hec = 4'b0;
  endtask
  task automatic wall(input logic [3:0] code);
    collision = 1'b1;
    hec = code;
    tick();
    collision = 1'b0;
    hec = 4'b0;
  endtask
  initial begin
    int mx;
    reset = 1'b1; sof = 1'b0; collision = 1'b0; collision1 = 1'b0; hec = 4'b0; ball = 11'd0;
    tbl[0]  = '{300, 4'b0000, 0};
    tbl[1]  = '{300, 4'b0000, 1};
    tbl[2]  = '{0,   4'b0000, 1};
    tbl[3]  = '{6,   4'b0000, 2};
    tbl[4]  = '{6,   4'b0000, 2};
    tbl[5]  = '{300, 4'b0001, 2};
    tbl[6]  = '{300, 4'b0100, 3};
    tbl[7]  = '{0,   4'b0000, 3};
    tbl[8]  = '{290, 4'b0000, 3};
    tbl[9]  = '{290, 4'b0000, 4};
    tbl[10] = '{290, 4'b0000, 5};
    tbl[11] = '{0,   4'b0100, 5};
    tbl[12] = '{0,   4'b0001, 4};
    tbl[13] = '{0,   4'b0000, 4};
    tbl[14] = '{142, 4'b0000, 5};
    tbl[15] = '{142, 4'b0000, 6};
    tick();
    do_reset();
    chk("reset_kick", kick, 0);
    chk("reset_y", tly, 0);
    chk("reset_x", tlx, 120);
    for (int i = 0; i < 16; i++) begin
      ball = 11'(tbl[i].ball);
      if (tbl[i].hec != 4'b0) wall(tbl[i].hec);
      else tick();
      frame();
      chk($sformatf("vec%0d_y", i), tly, tbl[i].exp_y);
      chk($sformatf("vec%0d_kick", i), kick, 0);
    end
    do_reset();
    ball = 11'd300;
    for (int i = 0; i < 5; i++) tick();
    chk("no_sof_hold", tly, 0);
    for (int i = 0; i < 51; i++) frame();
    chk("track_51", tly, 39);
    frame();
    chk("track_52", tly, 40);
    for (int i = 0; i < 5; i++) frame();
    chk("track_hold", tly, 40);
    ball = 11'd0;
    frame();
    chk("up_move", tly, 39);
    wall(4'b0100);
    tick();
    frame();
    chk("up_blocked", tly, 39);
    frame();
    frame();
    chk("up_resume", tly, 38);
    do_reset();
    ball = 11'd479;
    mx = 0;
    for (int i = 0; i < 260; i++) begin
      frame();
      if (int'(tly) > mx) mx = int'(tly);
    end
    chk("clamp_max", mx, 192);
    chk("clamp_y", tly, 192);
    do_reset();
    ball = 11'd0;
    for (int i = 0; i < 5; i++) frame();
    chk("clamp_zero", tly, 0);
    hit(4'b0010);
    chk("hit_unused_edge", kick, 0);
    hit(4'b0001);
    chk("kick_start", kick, 1);
    for (int i = 0; i < 14; i++) frame();
    chk("kick_14", kick, 1);
    frame();
    chk("kick_end", kick, 0);
    for (int i = 0; i < 10; i++) frame();
    hit(4'b0100);
    chk("cool_ignore", kick, 0);
    for (int i = 0; i < 19; i++) frame();
    hit(4'b1000);
    chk("cool_29_ignore", kick, 0);
    frame();
    sof = 1'b1;
    hit(4'b1000);
    sof = 1'b0;
    chk("kick_on_sof", kick, 1);
    for (int i = 0; i < 14; i++) frame();
    chk("sof_not_counted", kick, 1);
    frame();
    chk("sof_kick_end", kick, 0);
    do_reset();
    ball = 11'd300;
    hit(4'b0001);
    for (int i = 0; i < 5; i++) frame();
    chk("mid_kick", kick, 1);
    chk("mid_kick_y", tly, 3);
    reset = 1'b1; sof = 1'b1; collision = 1'b1; collision1 = 1'b1; hec = 4'b0101;
    tick();
    reset = 1'b0; sof = 1'b0; collision = 1'b0; collision1 = 1'b0; hec = 4'b0;
    chk("rst_kick", kick, 0);
    chk("rst_y", tly, 0);
    hit(4'b0001);
    chk("rekick", kick, 1);
`ifdef BOT_PREDICT_EN
    do_reset();
    ball = 11'd100;
    frame();
    ball = 11'd110;
    tick();
    chk("pred_target", int'(dut.target_y), 130);
    chk("pred_err", int'(dut.err), 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
